// File: rtl/mc_controller.sv
// Multi-cycle sequencing controller for the RV32 core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB so that fetch and
// load/store can share one single-port memory with variable wait states.
// Control enables and mux selects are combinational from the state, the
// latched opcode and the memory handshake.
// Also keeps the retired-instruction counter and a sticky trap.
`timescale 1ns/1ps

module mc_controller #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  ir_opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        alu_force_add,
  output logic [2:0]  state,
  output logic        retire,
  output logic [31:0] instret,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic [7:0] wait_cnt;
  logic [1:0] nxt_cause;

  logic is_op, is_opimm, is_load, is_store, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, is_legal;
  logic timeout, waiting;
  logic [1:0] alu_a_dec;
  logic       alu_b_dec;
  logic       force_add_dec;

  assign is_op     = (ir_opcode == OPC_OP);
  assign is_opimm  = (ir_opcode == OPC_OPIMM);
  assign is_load   = (ir_opcode == OPC_LOAD);
  assign is_store  = (ir_opcode == OPC_STORE);
  assign is_branch = (ir_opcode == OPC_BRANCH);
  assign is_jal    = (ir_opcode == OPC_JAL);
  assign is_jalr   = (ir_opcode == OPC_JALR);
  assign is_lui    = (ir_opcode == OPC_LUI);
  assign is_auipc  = (ir_opcode == OPC_AUIPC);
  assign is_legal  = is_op | is_opimm | is_load | is_store | is_branch |
                     is_jal | is_jalr | is_lui | is_auipc;

  assign timeout = (wait_cnt == WAIT_LIM);
  // Counter runs only while a memory request is outstanding and unanswered;
  // every other cycle leaves it at zero, so each entry to FETCH/MEM starts clean.
  assign waiting = ((cur_state == S_FETCH) || (cur_state == S_MEM)) && !mem_ready;

  assign state = cur_state;

  // Operand selects as decoded for EXEC, held through MEM and WB.
  assign alu_a_dec     = is_lui ? 2'd2 : (is_auipc ? 2'd1 : 2'd0);
  assign alu_b_dec     = !(is_op | is_branch);
  assign force_add_dec = is_load | is_store | is_jalr | is_auipc | is_lui;

  // Next-state selection; a completed handshake wins over a timeout.
  always_comb begin
    nxt_state = cur_state;
    nxt_cause = 2'd0;
    case (cur_state)
      S_FETCH: begin
        if (mem_ready) begin
          nxt_state = S_DECODE;
        end else if (timeout) begin
          nxt_state = S_TRAP;
          nxt_cause = 2'd2;
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          nxt_state = S_TRAP;
          nxt_cause = 2'd1;
        end else begin
          nxt_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch)                nxt_state = S_FETCH;
        else if (is_load || is_store) nxt_state = S_MEM;
        else                          nxt_state = S_WB;
      end
      S_MEM: begin
        if (mem_ready) begin
          nxt_state = is_store ? S_FETCH : S_WB;
        end else if (timeout) begin
          nxt_state = S_TRAP;
          nxt_cause = 2'd3;
        end
      end
      S_WB:    nxt_state = S_FETCH;
      S_TRAP:  nxt_state = S_TRAP;
      default: nxt_state = S_FETCH;
    endcase
  end

  // State, wait counter, retired count and sticky trap registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur_state  <= S_FETCH;
      wait_cnt   <= '0;
      instret    <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'd0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= waiting ? wait_cnt + 8'd1 : '0;
      instret   <= instret + 32'(retire);
      if ((nxt_state == S_TRAP) && (cur_state != S_TRAP)) begin
        trap       <= 1'b1;
        trap_cause <= nxt_cause;
      end
    end
  end

  // Control outputs; enables that commit architectural state are masked by RST.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = 2'd0;
    reg_we        = 1'b0;
    wb_sel        = 2'd0;
    alu_a_sel     = 2'd0;
    alu_b_sel     = 1'b0;
    alu_force_add = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready && !RST;
      end
      S_EXEC: begin
        alu_a_sel     = alu_a_dec;
        alu_b_sel     = alu_b_dec;
        alu_force_add = force_add_dec;
        if (is_branch) begin
          pc_we  = !RST;
          pc_sel = {1'b0, branch_taken};
        end
      end
      S_MEM: begin
        mem_req       = 1'b1;
        mem_addr_sel  = 1'b1;
        mem_we        = is_store;
        alu_a_sel     = alu_a_dec;
        alu_b_sel     = alu_b_dec;
        alu_force_add = force_add_dec;
        if (is_store && mem_ready) begin
          pc_we  = !RST;
          pc_sel = 2'd0;
        end
      end
      S_WB: begin
        reg_we        = !RST;
        pc_we         = !RST;
        wb_sel        = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        pc_sel        = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        alu_a_sel     = alu_a_dec;
        alu_b_sel     = alu_b_dec;
        alu_force_add = force_add_dec;
      end
      default: ;
    endcase
    retire = pc_we;
  end

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: vector table, corner-case sequences and
// randomized instruction streams against an instruction-level reference model.
`timescale 1ns/1ps

module tb_mc_controller;

  localparam int unsigned MAXW = 15;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  logic        CLK, RST;
  logic [6:0]  ir_opcode;
  logic        branch_taken, mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0]  pc_sel;
  logic        reg_we;
  logic [1:0]  wb_sel, alu_a_sel;
  logic        alu_b_sel, alu_force_add;
  logic [2:0]  state;
  logic        retire;
  logic [31:0] instret;
  logic        trap;
  logic [1:0]  trap_cause;

  mc_controller #(.MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .RST(RST), .ir_opcode(ir_opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_force_add(alu_force_add), .state(state), .retire(retire),
    .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned model_instret = 0;

  typedef struct {
    logic [2:0] st;
    logic       rdy;
  } phase_t;

  typedef struct {
    logic [6:0] op;
    int         fw;
    int         dw;
    logic       tk;
    int         cyc;
    logic [1:0] cause;
  } vec_t;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic bit legal(logic [6:0] op);
    return op == OP_R || op == OP_I || op == OP_LD || op == OP_ST || op == OP_BR ||
           op == OP_JAL || op == OP_JR || op == OP_LUI || op == OP_AUI;
  endfunction

  // Expected controls for one cycle, described from the instruction's role in
  // that phase rather than from any state encoding of the design.
  task automatic expect_ctrl(input logic [2:0] st, input logic [6:0] op,
                             input logic rdy, input logic tk,
                             output logic [17:0] ev, output logic [17:0] mk);
    bit fetch, mem, exe, wb, is_st, is_ld, is_jmp, commit, alu_ok;
    logic [1:0] pcs, wbs, aa;
    logic bb, fa;
    fetch  = (st == 3'd0);
    exe    = (st == 3'd2);
    mem    = (st == 3'd3);
    wb     = (st == 3'd4);
    is_st  = (op == OP_ST);
    is_ld  = (op == OP_LD);
    is_jmp = (op == OP_JAL) || (op == OP_JR);
    commit = (exe && op == OP_BR) || (mem && is_st && rdy) || wb;
    if (exe)            pcs = {1'b0, tk};
    else if (!wb)       pcs = 2'd0;
    else if (op == OP_JAL) pcs = 2'd1;
    else if (op == OP_JR)  pcs = 2'd2;
    else                pcs = 2'd0;
    wbs = is_ld ? 2'd1 : (is_jmp ? 2'd2 : 2'd0);
    aa  = (op == OP_LUI) ? 2'd2 : ((op == OP_AUI) ? 2'd1 : 2'd0);
    bb  = (op != OP_R);
    fa  = is_ld || is_st || op == OP_JR || op == OP_AUI || op == OP_LUI;
    alu_ok = (exe || mem || wb) && op != OP_BR && op != OP_JAL;
    ev = {st, 1'(fetch || mem), 1'(mem && is_st), 1'(mem), 1'(fetch && rdy),
          1'(commit), pcs, 1'(wb), wbs, aa, bb, fa, 1'(commit)};
    mk = {3'b111, 5'b11111, {2{1'(commit)}}, 1'b1, {2{1'(wb)}}, {4{1'(alu_ok)}}, 1'b1};
  endtask

  // Reference model: the sequence of (phase, mem_ready) an instruction goes
  // through, given its wait-state budget; ends at retire or at trap entry.
  task automatic build_plan(input logic [6:0] op, input int fw, input int dw,
                            output phase_t q[$], output logic [1:0] cause);
    q = {};
    cause = 2'd0;
    for (int i = 0; i < fw && i <= int'(MAXW); i++) q.push_back('{3'd0, 1'b0});
    if (fw > int'(MAXW)) begin cause = 2'd2; return; end
    q.push_back('{3'd0, 1'b1});
    q.push_back('{3'd1, 1'b0});
    if (!legal(op)) begin cause = 2'd1; return; end
    q.push_back('{3'd2, 1'b0});
    if (op == OP_BR) return;
    if (op == OP_LD || op == OP_ST) begin
      for (int i = 0; i < dw && i <= int'(MAXW); i++) q.push_back('{3'd3, 1'b0});
      if (dw > int'(MAXW)) begin cause = 2'd3; return; end
      q.push_back('{3'd3, 1'b1});
      if (op == OP_ST) return;
    end
    q.push_back('{3'd4, 1'b0});
  endtask

  // Entered and left at posedge+1. Counts the cycles the DUT actually spends
  // until it retires or traps.
  task automatic run_instr(input logic [6:0] op, input int fw, input int dw,
                           input logic tk, output int cyc, output int exp_cyc,
                           output logic [1:0] exp_cause);
    phase_t q[$];
    logic [17:0] ev, mk, av;
    logic ret;
    build_plan(op, fw, dw, q, exp_cause);
    exp_cyc = q.size();
    cyc = 0;
    for (int i = 0; i < q.size(); i++) begin
      mem_ready = q[i].rdy;
      branch_taken = tk;
      ir_opcode = op;
      #2;
      if (state == 3'd7) break;
      expect_ctrl(q[i].st, op, q[i].rdy, tk, ev, mk);
      av = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we,
            wb_sel, alu_a_sel, alu_b_sel, alu_force_add, retire};
      chk($sformatf("ctrl op=%b ph%0d", op, i), 32'(av & mk), 32'(ev & mk));
      cyc++;
      ret = retire;
      @(posedge CLK); #1;
      if (ret) break;
    end
    mem_ready = 1'b0;
  endtask

  task automatic do_reset(input bit check);
    RST = 1'b1;
    mem_ready = 1'b1;
    branch_taken = 1'b1;
    ir_opcode = OP_BR;
    @(posedge CLK); #1;
    if (check) begin
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_fetch_outs", 32'({mem_req, mem_we, mem_addr_sel}), 32'b100);
      chk("rst_enables", 32'({ir_we, pc_we, reg_we, retire}), 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_trap", 32'({trap, trap_cause}), 32'd0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    mem_ready = 1'b0;
    model_instret = 0;
  endtask

  task automatic step(input logic rdy, input logic [2:0] exp_st, input string nm);
    mem_ready = rdy;
    #2;
    chk(nm, 32'(state), 32'(exp_st));
    @(posedge CLK); #1;
  endtask

  task automatic post_checks(input string nm, input int cyc, input int exp_cyc,
                             input logic [1:0] exp_cause);
    chk({nm, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({nm, "_trap"}, 32'(trap), 32'(exp_cause != 2'd0));
    chk({nm, "_cause"}, 32'(trap_cause), 32'(exp_cause));
    if (exp_cause != 2'd0) chk({nm, "_state"}, 32'(state), 32'd7);
    else model_instret++;
    chk({nm, "_instret"}, instret, model_instret);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    vec_t v;
    int cyc, ecyc;
    logic [1:0] ecause;
    logic [6:0] legal_ops[9];
    logic [6:0] op;
    int fw, dw;

    tbl[0]  = '{OP_I,   0,  0, 1'b0,  4, 2'd0};
    tbl[1]  = '{OP_LD,  2,  1, 1'b0,  8, 2'd0};
    tbl[2]  = '{OP_BR,  0,  0, 1'b1,  3, 2'd0};
    tbl[3]  = '{OP_BR,  0,  0, 1'b0,  3, 2'd0};
    tbl[4]  = '{OP_ST,  0,  0, 1'b0,  4, 2'd0};
    tbl[5]  = '{OP_LD,  0,  0, 1'b0,  5, 2'd0};
    tbl[6]  = '{OP_JAL, 0,  0, 1'b0,  4, 2'd0};
    tbl[7]  = '{OP_JR,  0,  0, 1'b0,  4, 2'd0};
    tbl[8]  = '{OP_LUI, 0,  0, 1'b0,  4, 2'd0};
    tbl[9]  = '{OP_AUI, 1,  0, 1'b0,  5, 2'd0};
    tbl[10] = '{OP_R,   0,  0, 1'b1,  4, 2'd0};
    tbl[11] = '{OP_I,  15,  0, 1'b0, 19, 2'd0};
    tbl[12] = '{OP_ST,  0, 15, 1'b0, 19, 2'd0};
    tbl[13] = '{OP_I,  16,  0, 1'b0, 16, 2'd2};
    tbl[14] = '{OP_ST,  0, 16, 1'b0, 19, 2'd3};

    legal_ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JR, OP_LUI, OP_AUI};

    do_reset(1);

    for (int i = 0; i < 15; i++) begin
      v = tbl[i];
      run_instr(v.op, v.fw, v.dw, v.tk, cyc, ecyc, ecause);
      post_checks($sformatf("vec%0d", i), cyc, v.cyc, v.cause);
      if (v.cause != 2'd0) do_reset(0);
    end

    // Illegal opcode: trap after DECODE, then held with no memory traffic.
    run_instr(7'b0000000, 0, 0, 1'b0, cyc, ecyc, ecause);
    post_checks("illegal", cyc, 2, 2'd1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #2;
      chk($sformatf("trap_hold%0d", i),
          32'({state, mem_req, ir_we, pc_we, reg_we, retire}), 32'({3'd7, 5'b0}));
      @(posedge CLK); #1;
    end
    chk("trap_hold_instret", instret, model_instret);
    do_reset(0);

    // Reset while a store is stalled in MEM: nothing commits.
    ir_opcode = OP_ST;
    branch_taken = 1'b0;
    step(1'b1, 3'd0, "st_fetch");
    step(1'b0, 3'd1, "st_decode");
    step(1'b0, 3'd2, "st_exec");
    step(1'b0, 3'd3, "st_mem_wait");
    mem_ready = 1'b0;
    #1;
    chk("st_mem_we", 32'({mem_req, mem_we}), 32'b11);
    RST = 1'b1;
    #1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_mem", 32'({mem_req, mem_we, mem_addr_sel}), 32'b100);
    mem_ready = 1'b1;
    #1;
    chk("midrst_commit", 32'({pc_we, retire, ir_we}), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    mem_ready = 1'b0;
    model_instret = 0;
    chk("midrst_instret", instret, 32'd0);
    run_instr(OP_I, 0, 0, 1'b0, cyc, ecyc, ecause);
    post_checks("after_rst", cyc, 4, 2'd0);

    // Randomized instruction stream against the plan model.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        op = 7'($urandom_range(0, 127));
        while (legal(op)) op = 7'($urandom_range(0, 127));
      end else begin
        op = legal_ops[$urandom_range(0, 8)];
      end
      fw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(MAXW - 1, MAXW + 1))
                                        : int'($urandom_range(0, 3));
      dw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(MAXW - 1, MAXW + 1))
                                        : int'($urandom_range(0, 3));
      run_instr(op, fw, dw, 1'($urandom_range(0, 1)), cyc, ecyc, ecause);
      post_checks($sformatf("rnd%0d", n), cyc, ecyc, ecause);
      if (ecause != 2'd0 || trap) do_reset(0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle sequencing controller for the RV32 core. It replaces the single-cycle "everything every clock" flow with a FETCH/DECODE/EXEC/MEM/WB state machine so that instruction fetch and load/store can share one single-port memory with variable wait states. It drives the write enables and mux selects for the PC, instruction register, register file, ALU operand muxes and memory port. It also keeps a retired-instruction counter and raises a sticky trap on illegal opcodes or memory timeouts.

## Interface

Parameters:
- MAX_WAIT, 15: maximum consecutive cycles a memory request may wait with mem_ready low before trapping (1..255).

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ir_opcode  in  7  opcode field of the latched instruction register (inst[6:0]).
- branch_taken  in  1  branch comparator result for the current instruction.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write (store) when mem_req=1.
- mem_addr_sel  out  1  0=PC (fetch), 1=ALU result (data).
- ir_we  out  1  latch fetched word into instruction register.
- pc_we  out  1  update PC at the next edge.
- pc_sel  out  2  0=PC+4, 1=PC+imm (taken branch/JAL), 2=ALU result (JALR).
- reg_we  out  1  register file write enable.
- wb_sel  out  2  0=ALU, 1=memory read data, 2=PC+4.
- alu_a_sel  out  2  0=rs1, 1=PC, 2=zero.
- alu_b_sel  out  1  0=rs2, 1=imm.
- alu_force_add  out  1  override decoder ALU control with ADD.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- retire  out  1  one-cycle pulse when an instruction completes.
- instret  out  32  retired-instruction count.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  0=none, 1=illegal opcode, 2=fetch timeout, 3=data timeout.

## Operation

- Legal opcodes: OP 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111. All others are illegal.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - mem_ready=1: ir_we=1, go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: register file read only.
  - Illegal opcode: go to TRAP with cause 1.
  - Otherwise go to EXEC.
- EXEC, ALU operand selects by opcode:
  - OP: a=rs1, b=rs2.
  - OP-IMM: a=rs1, b=imm.
  - LOAD, STORE, JALR: a=rs1, b=imm, force_add.
  - AUIPC: a=PC, b=imm, force_add.
  - LUI: a=zero, b=imm, force_add.
- EXEC, next state by opcode:
  - BRANCH: pc_we=1, pc_sel=branch_taken?1:0, retire, go to FETCH.
  - LOAD and STORE: go to MEM.
  - Everything else: go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(STORE). ALU selects are held as in EXEC.
  - On mem_ready, STORE: pc_we=1, pc_sel=0, retire, go to FETCH.
  - On mem_ready, LOAD: go to WB.
- WB: reg_we=1, pc_we=1, retire, go to FETCH.
  - wb_sel: LOAD=1, JAL/JALR=2, others=0.
  - pc_sel: JAL=1, JALR=2, others=0.
  - ALU selects are held as in EXEC.
- TRAP: every enable and mem_req is 0, trap=1. The state is held until RST.
- Wait counter (8 bit):
  - Cleared on every entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM with mem_ready=0.
  - If the count equals MAX_WAIT and mem_ready=0, the next state is TRAP with cause 2 (FETCH) or 3 (MEM).
  - mem_ready=1 in the same cycle has priority over the timeout.
- mem_ready is ignored whenever mem_req=0.
- instret increments on each retire and wraps from 0xFFFFFFFF to 0.

## Timing

- Reset values: state=FETCH, instret=0, trap=0, trap_cause=0, wait counter=0.
- Combinational outputs follow from state. With RST high, the FETCH outputs are driven (mem_req=1, mem_addr_sel=0, mem_we=0); every enable and retire is 0, because ir_we and pc_we are gated by mem_ready and RST.
- Registered: state, wait counter, instret, trap, trap_cause.
- Combinational outputs:
  - mem_req, mem_we, mem_addr_sel, reg_we, wb_sel and all ALU selects depend on state and ir_opcode.
  - ir_we, pc_we and retire additionally depend on mem_ready and branch_taken (Mealy).
- Latency with zero wait states:
  - BRANCH: 3 cycles.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- RST asserted mid-instruction (e.g. in MEM with mem_we=1): state returns to FETCH immediately, with no write, retire or PC update. When RST deasserts, fetch restarts.
- Illegal opcode: trap=1 on the edge ending DECODE; instret is unchanged.

## Test plan

- ADDI (opcode 0010011), mem_ready always 1 -> states 0,1,2,4. reg_we=1 and pc_we=1 in cycle 4 only. retire pulses once and instret=1.
- LOAD with 2 fetch wait cycles and 1 data wait cycle -> FETCH for 3 cycles, then DECODE, EXEC, MEM for 2 cycles, then WB with wb_sel=1. Total 8 cycles, instret=1.
- BRANCH, branch_taken=1 then 0 -> EXEC shows pc_sel=1 then pc_sel=0, pc_we=1 each time. Each takes 3 cycles and reg_we is never asserted.
- Opcode 0000000 -> TRAP after DECODE with trap_cause=1. No retire. State holds 7 through 20 further cycles with mem_req=0.
- mem_ready held 0 in FETCH, MAX_WAIT=15 -> state=7 and trap_cause=2 after 16 cycles in FETCH. Repeat with ready arriving in wait cycle 15 -> no trap, proceeds to DECODE.
- STORE stalled in MEM, RST pulsed -> mem_req and mem_we return to the FETCH values immediately (mem_req=1, mem_we=0). State=0, instret=0, and the store never completes.
